// File: rtl/seed_gen_param.sv
// Seed generator: free-running basis (counter or Galois LFSR) expanded into a
// wide seed and held behind a valid/ready handshake until the consumer accepts it.
module seed_gen_param #(
  parameter int                 BASIS_W   = 8,
  parameter int                 SEED_W    = 32,
  parameter logic [BASIS_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [BASIS_W-1:0] LFSR_INIT = 8'h01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               mode,
  input  logic               enable,
  input  logic               capture_req,
  input  logic               seed_ready,
  output logic               seed_valid,
  output logic [SEED_W-1:0]  seed,
  output logic [BASIS_W-1:0] basis
);

  localparam int SEGS = SEED_W / BASIS_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  generate
    if (SEED_W % BASIS_W != 0) begin : g_bad_seed_w
      $error("seed_gen_param: SEED_W must be a multiple of BASIS_W");
    end
    if (BASIS_W < 2) begin : g_bad_basis_w
      $error("seed_gen_param: BASIS_W must be at least 2");
    end
    if (LFSR_INIT == '0) begin : g_bad_init
      $error("seed_gen_param: LFSR_INIT must be nonzero");
    end
  endgenerate

  logic [BASIS_W-1:0] basis_reg, basis_next;
  logic [BASIS_W-1:0] basis_rev;
  logic [SEED_W-1:0]  expansion;
  logic [SEED_W-1:0]  seed_reg, seed_next;
  logic [0:0]         state_reg, state_next;

  genvar gi;
  generate
    for (gi = 0; gi < BASIS_W; gi++) begin : g_rev
      assign basis_rev[gi] = basis_reg[BASIS_W-1-gi];
    end
    // Segment 0 occupies the most significant bits; even segments are reversed.
    for (gi = 0; gi < SEGS; gi++) begin : g_seg
      if (gi % 2 == 0) begin : g_even
        assign expansion[SEED_W-1-gi*BASIS_W -: BASIS_W] = basis_rev;
      end else begin : g_odd
        assign expansion[SEED_W-1-gi*BASIS_W -: BASIS_W] = basis_reg;
      end
    end
  endgenerate

  always_comb begin
    basis_next = basis_reg;
    if (clear) begin
      basis_next = mode ? LFSR_INIT : '0;
    end else if (enable) begin
      if (!mode) begin
        basis_next = basis_reg + BASIS_W'(1);
      end else if (basis_reg == '0) begin
        // All-zero is the LFSR's lock-up state; kick it back onto the cycle.
        basis_next = LFSR_INIT;
      end else begin
        basis_next = (basis_reg >> 1) ^ (basis_reg[0] ? LFSR_TAPS : '0);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    seed_next  = seed_reg;
    case (state_reg)
      IDLE: begin
        if (capture_req) begin
          seed_next  = expansion;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (seed_ready) begin
          if (capture_req) begin
            seed_next = expansion;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      basis_reg <= '0;
      seed_reg  <= '0;
      state_reg <= IDLE;
    end else begin
      basis_reg <= basis_next;
      seed_reg  <= seed_next;
      state_reg <= state_next;
    end
  end

  assign basis      = basis_reg;
  assign seed       = seed_reg;
  assign seed_valid = (state_reg == HOLD);

endmodule
